// File: rtl/scs8hd_scan_chain_if.sv
// Handshake and chain-facing signals of the scan-chain controller.
// The sequencer/bench side uses the master modport, the controller the slave modport.
`timescale 1ns/1ps
interface scs8hd_scan_chain_ctl_if #(
  parameter int CHAIN_LEN = 8
);
  logic                 START;
  logic [CHAIN_LEN-1:0] PATTERN;
  logic                 CAPTURE;
  logic                 SO;
  logic                 SCE;
  logic                 SCD;
  logic                 CAP_DE;
  logic                 BUSY;
  logic                 DONE;
  logic [CHAIN_LEN-1:0] RESP;

  modport master (
    output START, PATTERN, CAPTURE, SO,
    input  SCE, SCD, CAP_DE, BUSY, DONE, RESP
  );

  modport slave (
    input  START, PATTERN, CAPTURE, SO,
    output SCE, SCD, CAP_DE, BUSY, DONE, RESP
  );
endinterface

// File: rtl/scs8hd_scan_chain_ctl.sv
// Scan-chain controller: shifts a parallel pattern into a CHAIN_LEN-deep chain while
// unloading its previous contents, then optionally pulses CAP_CYCLES functional captures.
`timescale 1ns/1ps
module scs8hd_scan_chain_ctl #(
  parameter int CHAIN_LEN  = 8,
  parameter int CAP_CYCLES = 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  scs8hd_scan_chain_ctl_if.slave        bus
);
  localparam int CW  = $clog2(CHAIN_LEN);
  localparam int CCW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CAPT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [CCW-1:0]       r_ccnt;
  logic [CHAIN_LEN-1:0] r_pat;
  logic                 r_cap;
  logic                 r_sce;
  logic                 r_scd;
  logic                 r_cap_de;
  logic                 r_busy;
  logic                 r_done;
  logic [CHAIN_LEN-1:0] r_resp;

  // Outputs are computed one edge ahead so that each registered value equals the
  // state-based value the chain must see during the following cycle.
  // NOTE: every register here uses non-blocking assignment so all of them update
  // from the same pre-edge values, exactly like the chain flops they drive.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ccnt   <= '0;
      r_pat    <= '0;
      r_cap    <= 1'b0;
      r_sce    <= 1'b0;
      r_scd    <= 1'b0;
      r_cap_de <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_resp   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sce    <= 1'b0;
          r_scd    <= 1'b0;
          r_cap_de <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          if (bus.START) begin
            r_pat   <= bus.PATTERN;
            r_cap   <= bus.CAPTURE;
            r_cnt   <= CW'(CHAIN_LEN - 1);
            r_sce   <= 1'b1;
            r_scd   <= bus.PATTERN[CHAIN_LEN-1];
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          r_resp <= {r_resp[CHAIN_LEN-2:0], bus.SO};
          if (r_cnt == '0) begin
            r_sce <= 1'b0;
            r_scd <= 1'b0;
            if (r_cap) begin
              r_cap_de <= 1'b1;
              r_ccnt   <= CCW'(CAP_CYCLES - 1);
              r_state  <= CAPT;
            end else begin
              r_done  <= 1'b1;
              r_state <= FINISH;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
            r_scd <= r_pat[r_cnt - 1'b1];
          end
        end

        CAPT: begin
          if (r_ccnt == '0) begin
            r_cap_de <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= FINISH;
          end else begin
            r_ccnt <= r_ccnt - 1'b1;
          end
        end

        FINISH: begin
          // START is deliberately not looked at here; it is only sampled in IDLE.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.SCE    = r_sce;
  assign bus.SCD    = r_scd;
  assign bus.CAP_DE = r_cap_de;
  assign bus.BUSY   = r_busy;
  assign bus.DONE   = r_done;
  assign bus.RESP   = r_resp;
endmodule

// File: tb/tb_scs8hd_scan_chain_ctl.sv
// Directed bench: an 8-cell and a 2-cell controller, each driving a behavioural
// chain of scan data-enable flops whose functional D input is its own inverted Q.
`timescale 1ns/1ps
module tb_scs8hd_scan_chain_ctl;
  logic CLK;
  logic RESET;
  logic clk_on;

  scs8hd_scan_chain_ctl_if #(.CHAIN_LEN(8)) ifa ();
  scs8hd_scan_chain_ctl_if #(.CHAIN_LEN(2)) ifb ();

  scs8hd_scan_chain_ctl #(.CHAIN_LEN(8), .CAP_CYCLES(1)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(ifa)
  );
  scs8hd_scan_chain_ctl #(.CHAIN_LEN(2), .CAP_CYCLES(15)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(ifb)
  );

  initial begin
    CLK = 1'b0;
    wait (clk_on);
    forever #5 CLK = ~CLK;
  end

  // Behavioural chains: shift when SCE, capture ~Q when CAP_DE, else hold.
  logic [7:0] chain_a, load_val_a;
  logic [1:0] chain_b, load_val_b;
  logic       load_a, load_b;

  always @(posedge CLK) begin
    if (load_a)          chain_a <= load_val_a;
    else if (ifa.SCE)    chain_a <= {chain_a[6:0], ifa.SCD};
    else if (ifa.CAP_DE) chain_a <= ~chain_a;
    if (load_b)          chain_b <= load_val_b;
    else if (ifb.SCE)    chain_b <= {chain_b[0], ifb.SCD};
    else if (ifb.CAP_DE) chain_b <= ~chain_b;
  end

  assign ifa.SO = chain_a[7];
  assign ifb.SO = chain_b[1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-operation observations.
  int         busy_n, sce_n, cap_n, done_n, overlap_n;
  logic       last_done;
  logic [7:0] scd_seq;

  task automatic preload_a(input logic [7:0] v);
    @(negedge CLK);
    load_val_a = v; load_a = 1'b1;
    @(negedge CLK);
    load_a = 1'b0;
  endtask

  task automatic preload_b(input logic [1:0] v);
    @(negedge CLK);
    load_val_b = v; load_b = 1'b1;
    @(negedge CLK);
    load_b = 1'b0;
  endtask

  // Launch one operation on dut_a and record it cycle by cycle until BUSY drops.
  task automatic op_a(input logic [7:0] pat, input logic cap);
    @(negedge CLK);
    ifa.PATTERN = pat; ifa.CAPTURE = cap; ifa.START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ifa.START = 1'b0; ifa.PATTERN = ~pat; ifa.CAPTURE = ~cap;
    busy_n = 0; sce_n = 0; cap_n = 0; done_n = 0; overlap_n = 0;
    last_done = 1'b0; scd_seq = '0;
    for (int k = 0; k < 100 && ifa.BUSY; k++) begin
      busy_n++;
      if (ifa.SCE) begin sce_n++; scd_seq = {scd_seq[6:0], ifa.SCD}; end
      if (ifa.CAP_DE) cap_n++;
      if (ifa.CAP_DE && ifa.SCE) overlap_n++;
      if (ifa.DONE) done_n++;
      last_done = ifa.DONE;
      @(negedge CLK);
    end
    check("op_a_timeout", 32'(ifa.BUSY), 32'd0);
    check("op_a_done_idle", 32'(ifa.DONE), 32'd0);
  endtask

  task automatic op_b(input logic [1:0] pat, input logic cap);
    @(negedge CLK);
    ifb.PATTERN = pat; ifb.CAPTURE = cap; ifb.START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ifb.START = 1'b0; ifb.PATTERN = ~pat; ifb.CAPTURE = ~cap;
    busy_n = 0; sce_n = 0; cap_n = 0; done_n = 0; overlap_n = 0;
    last_done = 1'b0; scd_seq = '0;
    for (int k = 0; k < 100 && ifb.BUSY; k++) begin
      busy_n++;
      if (ifb.SCE) begin sce_n++; scd_seq = {scd_seq[6:0], ifb.SCD}; end
      if (ifb.CAP_DE) cap_n++;
      if (ifb.CAP_DE && ifb.SCE) overlap_n++;
      if (ifb.DONE) done_n++;
      last_done = ifb.DONE;
      @(negedge CLK);
    end
    check("op_b_timeout", 32'(ifb.BUSY), 32'd0);
  endtask

  initial begin
    int idle_n, bad_n, done_cnt;
    logic prev_done;
    clk_on = 1'b0; RESET = 1'b0;
    load_a = 1'b0; load_b = 1'b0; load_val_a = '0; load_val_b = '0;
    ifa.START = 1'b0; ifa.PATTERN = '0; ifa.CAPTURE = 1'b0;
    ifb.START = 1'b0; ifb.PATTERN = '0; ifb.CAPTURE = 1'b0;

    // 1: asynchronous reset with the clock stopped.
    #1 RESET = 1'b1;
    #1;
    check("rst_outs_a", {ifa.SCE, ifa.SCD, ifa.CAP_DE, ifa.BUSY, ifa.DONE, 8'h00}, 32'd0);
    check("rst_resp_a", 32'(ifa.RESP), 32'd0);
    check("rst_outs_b", {ifb.SCE, ifb.SCD, ifb.CAP_DE, ifb.BUSY, ifb.DONE}, 32'd0);
    clk_on = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("post_rst_busy", 32'(ifa.BUSY), 32'd0);
    check("post_rst_sce", 32'(ifa.SCE), 32'd0);

    // 2: plain shift, chain preloaded 0xA5, pattern 0x3C.
    preload_a(8'hA5);
    op_a(8'h3C, 1'b0);
    check("t2_scd_seq", 32'(scd_seq), 32'h3C);
    check("t2_sce_cycles", busy_n > 0 ? 32'(sce_n) : 32'hFFFF, 32'd8);
    check("t2_busy_cycles", 32'(busy_n), 32'd9);
    check("t2_done_count", 32'(done_n), 32'd1);
    check("t2_done_last", 32'(last_done), 32'd1);
    check("t2_cap_cycles", 32'(cap_n), 32'd0);
    check("t2_chain", 32'(chain_a), 32'h3C);
    check("t2_resp", 32'(ifa.RESP), 32'hA5);
    repeat (3) @(negedge CLK);
    check("t2_resp_stable", 32'(ifa.RESP), 32'hA5);

    // 3: capture inverts the chain; the next unload sees the inverted contents.
    op_a(8'h0F, 1'b1);
    check("t3a_busy_cycles", 32'(busy_n), 32'd10);
    check("t3a_cap_cycles", 32'(cap_n), 32'd1);
    check("t3a_cap_sce_overlap", 32'(overlap_n), 32'd0);
    check("t3a_done_last", 32'(last_done), 32'd1);
    check("t3a_chain", 32'(chain_a), 32'hF0);
    op_a(8'h00, 1'b0);
    check("t3b_resp", 32'(ifa.RESP), 32'hF0);
    check("t3b_busy_cycles", 32'(busy_n), 32'd9);
    check("t3b_chain", 32'(chain_a), 32'h00);

    // 4: START held high: 9 busy cycles then exactly one idle cycle, repeating.
    @(negedge CLK);
    ifa.PATTERN = 8'h81; ifa.CAPTURE = 1'b0; ifa.START = 1'b1;
    @(posedge CLK);
    idle_n = 0; bad_n = 0; done_cnt = 0; prev_done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK);
      if (!ifa.BUSY) idle_n++;
      if (ifa.DONE) done_cnt++;
      if (prev_done && ifa.BUSY) bad_n++;
      prev_done = ifa.DONE;
    end
    ifa.START = 1'b0;
    check("t4_done_count", 32'(done_cnt), 32'd3);
    check("t4_idle_cycles", 32'(idle_n), 32'd3);
    check("t4_idle_after_done", 32'(bad_n), 32'd0);
    for (int k = 0; k < 50 && ifa.BUSY; k++) @(negedge CLK);
    check("t4_drain", 32'(ifa.BUSY), 32'd0);

    // 5: asynchronous reset after the 4th shift edge.
    @(negedge CLK);
    ifa.PATTERN = 8'hFF; ifa.CAPTURE = 1'b0; ifa.START = 1'b1;
    @(posedge CLK);
    @(negedge CLK) ifa.START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("t5_sce_before_rst", 32'(ifa.SCE), 32'd1);
    #1 RESET = 1'b1;
    #1;
    check("t5_sce_async", 32'(ifa.SCE), 32'd0);
    check("t5_busy_async", 32'(ifa.BUSY), 32'd0);
    check("t5_resp_cleared", 32'(ifa.RESP), 32'd0);
    repeat (2) @(negedge CLK);
    check("t5_no_done", 32'(ifa.DONE), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("t5_idle_after_rel", {ifa.BUSY, ifa.DONE}, 32'd0);
    preload_a(8'h5A);
    op_a(8'h96, 1'b0);
    check("t5_scd_seq", 32'(scd_seq), 32'h96);
    check("t5_busy_cycles", 32'(busy_n), 32'd9);
    check("t5_resp", 32'(ifa.RESP), 32'h5A);
    check("t5_chain", 32'(chain_a), 32'h96);

    // 6: two-cell chain with the longest capture phase.
    preload_b(2'b11);
    op_b(2'b10, 1'b1);
    check("t6_scd_seq", 32'(scd_seq), 32'h2);
    check("t6_sce_cycles", 32'(sce_n), 32'd2);
    check("t6_cap_cycles", 32'(cap_n), 32'd15);
    check("t6_busy_cycles", 32'(busy_n), 32'd18);
    check("t6_done_count", 32'(done_n), 32'd1);
    check("t6_done_last", 32'(last_done), 32'd1);
    check("t6_resp", 32'(ifb.RESP), 32'h3);
    check("t6_chain", 32'(chain_b), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
